// File: rtl/fltadd_seq_if.sv
// Start/done handshake plus byte-wide data-memory port shared by the fp16 add sequencer.
// master = sequencer side, slave = core/memory side.
interface fltadd_seq_if #(
    parameter int AW = 8
);
    logic          start;
    logic          done;
    logic          busy;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rd_data;
    logic [7:0]    mem_wr_data;
    logic          mem_we;

    modport master (
        input  start, mem_rd_data,
        output done, busy, mem_addr, mem_wr_data, mem_we
    );

    modport slave (
        output start, mem_rd_data,
        input  done, busy, mem_addr, mem_wr_data, mem_we
    );
endinterface

// File: rtl/fltadd_seq.sv
// Multi-cycle fp16 adder (truncating) working on operands in byte-wide data memory.
// Latency 4 + min(d,MAX_ALIGN) + 1 + max(1,left shifts) + 2 cycles from launch; no backpressure, memory read is asynchronous.
module fltadd_seq #(
    parameter int AW        = 8,
    parameter int OP_A_ADDR = 128,
    parameter int OP_B_ADDR = 130,
    parameter int RES_ADDR  = 132,
    parameter int MAX_ALIGN = 12
) (
    input  logic         clk,
    input  logic         reset,
    fltadd_seq_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ALIGN, S_ADD, S_NORM, S_STORE, S_DONE
    } state_t;

    localparam logic [4:0] MAX_A5 = 5'(MAX_ALIGN);

    state_t        state;
    logic          start_q;
    logic          done_r;
    logic          busy_r;
    logic [AW-1:0] addr_r;
    logic [7:0]    wdat_r;
    logic          we_r;
    logic [1:0]    ld_cnt;
    logic [7:0]    a_hi, a_lo, b_hi;
    logic          sign_l, sign_s;
    logic [5:0]    exp_r;
    logic [10:0]   mant_l, mant_s;
    logic [4:0]    align_cnt;
    logic          align_big;
    logic [11:0]   sum;
    logic [15:0]   res;
    logic          st_cnt;

    assign bus.done        = done_r;
    assign bus.busy        = busy_r;
    assign bus.mem_addr    = addr_r;
    assign bus.mem_wr_data = wdat_r;
    assign bus.mem_we      = we_r;

    // Operand unpack and magnitude swap, consumed in the last LOAD cycle while B LSB is on the bus.
    logic [15:0] op_a, op_b, op_l, op_s;
    logic [4:0]  exp_l_in, exp_s_in, d, align_n;
    logic [10:0] mant_l_in, mant_s_in;
    logic        big_in;

    always_comb begin
        op_a = {a_hi, a_lo};
        op_b = {b_hi, bus.mem_rd_data};
        op_l = op_a;
        op_s = op_b;
        if (op_a[14:0] < op_b[14:0]) begin
            op_l = op_b;
            op_s = op_a;
        end
        exp_l_in  = op_l[14:10];
        exp_s_in  = op_s[14:10];
        mant_l_in = (exp_l_in == 5'd0) ? 11'd0 : {1'b1, op_l[9:0]};
        mant_s_in = (exp_s_in == 5'd0) ? 11'd0 : {1'b1, op_s[9:0]};
        d         = exp_l_in - exp_s_in;
        big_in    = (d > MAX_A5);
        align_n   = big_in ? MAX_A5 : d;
    end

    // One normalisation step; norm_fin says whether this cycle produces the final result.
    logic        norm_fin;
    logic [15:0] norm_res;
    logic [11:0] sum_nx;
    logic [5:0]  exp_nx;

    always_comb begin
        norm_fin = 1'b1;
        norm_res = 16'h0000;
        sum_nx   = sum;
        exp_nx   = exp_r;
        if (sum[11]) begin
            if (exp_r + 6'd1 >= 6'd31)
                norm_res = {sign_l, 5'h1F, 10'h000};
            else
                norm_res = {sign_l, exp_r[4:0] + 5'd1, sum[10:1]};
        end else if (sum == 12'd0) begin
            norm_res = 16'h0000;
        end else if (sum[10]) begin
            norm_res = {sign_l, exp_r[4:0], sum[9:0]};
        end else if (exp_r <= 6'd1) begin
            norm_res = 16'h0000;
        end else begin
            sum_nx = {sum[10:0], 1'b0};
            exp_nx = exp_r - 6'd1;
            if (sum_nx[10])
                norm_res = {sign_l, exp_nx[4:0], sum_nx[9:0]};
            else
                norm_fin = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            start_q   <= 1'b0;
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
            addr_r    <= '0;
            wdat_r    <= 8'h00;
            we_r      <= 1'b0;
            ld_cnt    <= 2'd0;
            a_hi      <= 8'h00;
            a_lo      <= 8'h00;
            b_hi      <= 8'h00;
            sign_l    <= 1'b0;
            sign_s    <= 1'b0;
            exp_r     <= 6'd0;
            mant_l    <= 11'd0;
            mant_s    <= 11'd0;
            align_cnt <= 5'd0;
            align_big <= 1'b0;
            sum       <= 12'd0;
            res       <= 16'h0000;
            st_cnt    <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    start_q <= bus.start;
                    if (bus.start) begin
                        done_r <= 1'b0;
                    end else if (start_q) begin
                        state  <= S_LOAD;
                        busy_r <= 1'b1;
                        addr_r <= AW'(OP_A_ADDR);
                        ld_cnt <= 2'd0;
                    end
                end
                S_LOAD: begin
                    ld_cnt <= ld_cnt + 2'd1;
                    case (ld_cnt)
                        2'd0: begin a_hi <= bus.mem_rd_data; addr_r <= AW'(OP_A_ADDR + 1); end
                        2'd1: begin a_lo <= bus.mem_rd_data; addr_r <= AW'(OP_B_ADDR); end
                        2'd2: begin b_hi <= bus.mem_rd_data; addr_r <= AW'(OP_B_ADDR + 1); end
                        default: begin
                            sign_l    <= op_l[15];
                            sign_s    <= op_s[15];
                            exp_r     <= {1'b0, exp_l_in};
                            mant_l    <= mant_l_in;
                            mant_s    <= (big_in && align_n == 5'd0) ? 11'd0 : mant_s_in;
                            align_cnt <= align_n;
                            align_big <= big_in;
                            state     <= (align_n == 5'd0) ? S_ADD : S_ALIGN;
                        end
                    endcase
                end
                S_ALIGN: begin
                    mant_s    <= (align_cnt == 5'd1 && align_big) ? 11'd0 : (mant_s >> 1);
                    align_cnt <= align_cnt - 5'd1;
                    if (align_cnt == 5'd1)
                        state <= S_ADD;
                end
                S_ADD: begin
                    if (sign_l == sign_s)
                        sum <= {1'b0, mant_l} + {1'b0, mant_s};
                    else
                        sum <= {1'b0, mant_l} - {1'b0, mant_s};
                    state <= S_NORM;
                end
                S_NORM: begin
                    if (norm_fin) begin
                        res    <= norm_res;
                        state  <= S_STORE;
                        we_r   <= 1'b1;
                        addr_r <= AW'(RES_ADDR);
                        wdat_r <= norm_res[15:8];
                        st_cnt <= 1'b0;
                    end else begin
                        sum   <= sum_nx;
                        exp_r <= exp_nx;
                    end
                end
                S_STORE: begin
                    if (!st_cnt) begin
                        addr_r <= AW'(RES_ADDR + 1);
                        wdat_r <= res[7:0];
                        st_cnt <= 1'b1;
                    end else begin
                        we_r   <= 1'b0;
                        st_cnt <= 1'b0;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
